timer_ctrl: RTL and testbench
=============================

Name: timer_ctrl

Overview:
- Sequencing controller for the MM:SS BCD down-counter in the kitchen-timer datapath.
- Turns the raw start, stop and load push-buttons into clean control pulses.
- Derives the 1 Hz decrement tick from the 1 kHz system clock.
- Drives the counter's load/count strobes and watches its zero flag to raise a timed alarm.
- Sits between the board I/O and the counter; the counter's BCD value and preset inputs bypass this block.

Parameters:
TICK_DIV, 1000, c1khz cycles per decrement tick (1 s at 1 kHz).
DEBOUNCE, 20, consecutive stable synchronised samples needed to accept a button level change.
ALARM_SECS, 10, alarm duration in ticks before automatic return to IDLE.
BLINK_DIV, 500, c1khz cycles per alarm_blink half-period.

Ports:
c1khz  in  1  system clock, 1 kHz
rst  in  1  asynchronous reset, active-low
btn_start  in  1  raw start button, active-high, asynchronous
btn_stop  in  1  raw stop/pause button, active-high, asynchronous
btn_load  in  1  raw load button, active-high, asynchronous
zero  in  1  counter zero flag, asynchronous to c1khz
load  out  1  one-cycle load strobe to counter
count  out  1  one-cycle decrement strobe to counter
running  out  1  high while in RUN
alarm  out  1  high while in ALARM
alarm_blink  out  1  square wave while in ALARM, 0 otherwise
state  out  2  current FSM state, encoding below

Behaviour:
- Reset:
  - Asynchronous; when rst=0, all flops clear immediately.
  - State=IDLE; load, count, running, alarm and alarm_blink = 0.
  - Prescaler, alarm tick counter, blink counter and debounce state all = 0.
- Buttons:
  - Each button passes through a 2-FF synchroniser, then a debounce counter.
  - The debounced level changes only after the synchronised level has differed from it for DEBOUNCE consecutive cycles.
  - Each button produces a 1-cycle press pulse (p_start, p_stop, p_load) on the debounced 0->1 edge.
  - A held button produces exactly one pulse.
- zero input: 2-FF synchronised to zero_s. The counter raises zero only on a count strobe issued while it shows 00:00, so 00:00 is displayed for one full tick before the alarm starts.
- Prescaler:
  - Counts 0..TICK_DIV-1 in RUN only; tick = (prescaler==TICK_DIV-1).
  - Cleared on every entry to RUN, so the first decrement arrives exactly TICK_DIV cycles after entry.
  - Holds its value outside RUN.
- Strobes:
  - count and load are registered and asserted for exactly 1 cycle.
  - count is asserted the cycle after tick.
  - load is asserted the cycle after an accepted p_load.
  - count and load are never high in the same cycle.
- States (encoding): IDLE=0, RUN=1, PAUSE=2, ALARM=3.
- IDLE:
  - p_load -> pulse load, stay in IDLE.
  - p_start with zero_s=0 -> RUN.
  - p_start with zero_s=1 is ignored.
- RUN:
  - zero_s=1 -> ALARM. This has the highest priority and suppresses any pending count.
  - Otherwise p_stop -> PAUSE.
  - tick -> count strobe.
  - p_load and p_start are ignored.
- PAUSE:
  - p_start -> RUN.
  - p_load -> pulse load and go to IDLE.
  - p_stop is ignored.
- ALARM:
  - alarm=1. alarm_blink starts at 1 on entry and toggles every BLINK_DIV cycles.
  - An internal tick counter runs; after ALARM_SECS*TICK_DIV cycles -> IDLE.
  - Any press pulse -> IDLE immediately; p_load additionally pulses load.
  - alarm and alarm_blink drop to 0 on the cycle state leaves ALARM.
- Simultaneous events:
  - p_stop beats p_start in the same cycle.
  - p_load beats p_start in the same cycle.
  - zero_s beats everything in RUN.
- running = (state==RUN) and alarm = (state==ALARM), both registered with the state.
- A reset mid-operation (any state, including the middle of a strobe) returns to IDLE with strobes low. The counter is reset by the same rst.

Decomposition:
- timer_pkg:
  - state enum (IDLE, RUN, PAUSE, ALARM) and its 2-bit width.
  - Default values of TICK_DIV, DEBOUNCE, ALARM_SECS and BLINK_DIV.
  - Counter width constants, computed with $clog2.
- Sub-module btn_debounce (synchroniser + debounce counter + rising-edge pulse, DEBOUNCE parameter), instantiated three times.
- FSM, prescaler and alarm timing live in timer_ctrl.

Test Plan (TICK_DIV=10, DEBOUNCE=4, ALARM_SECS=2, BLINK_DIV=5):
- Reset then release, no buttons -> state=0 and all outputs 0 for 100 cycles. Assert rst=0 mid-RUN -> state=0 and count=0 in the same cycle.
- Hold btn_load 3 cycles -> no load pulse. Hold 20 cycles -> exactly one load pulse, 4+3 cycles after the rising edge.
- From IDLE with zero=0, press start -> RUN. count pulses exactly every 10 cycles, the first one 10 cycles after RUN entry; stop -> PAUSE and no further count; start -> RUN with the period restarting at 10.
- In RUN, raise zero -> ALARM 2-3 cycles later with no count that cycle. alarm_blink toggles every 5 cycles; auto return to IDLE after 20 cycles with alarm=0.
- In ALARM, press load -> one load pulse, state=IDLE, alarm=0. In IDLE with zero=1, press start -> stays IDLE.
- Press start and stop debounced in the same cycle from PAUSE -> stays in PAUSE. Press load and start together in IDLE -> load pulse, stays in IDLE.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and defaults for the kitchen-timer sequencing controller.
package timer_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } state_t;

  localparam int TICK_DIV_DEF   = 1000;
  localparam int DEBOUNCE_DEF   = 20;
  localparam int ALARM_SECS_DEF = 10;
  localparam int BLINK_DIV_DEF  = 500;

  // Counter width for a modulus n, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int TICK_W_DEF  = cnt_w(TICK_DIV_DEF);
  localparam int DEB_W_DEF   = cnt_w(DEBOUNCE_DEF);
  localparam int ALARM_W_DEF = cnt_w(ALARM_SECS_DEF * TICK_DIV_DEF);
  localparam int BLINK_W_DEF = cnt_w(BLINK_DIV_DEF);

endpackage

// File: rtl/timer_ctrl_btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, debounce counter and a
// registered one-cycle pulse on each accepted press.
module btn_debounce
  import timer_pkg::*;
#(
  parameter int DEBOUNCE = DEBOUNCE_DEF
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int CW = cnt_w(DEBOUNCE);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          pulse_q;
  logic [CW-1:0] cnt_q;
  logic          differ_s;
  logic          accept_s;

  assign differ_s = (sync2_q != level_q);
  assign accept_s = differ_s && (cnt_q == CW'(DEBOUNCE - 1));

  // Synchronise, count consecutive differing samples, flip level on the last one.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      pulse_q <= accept_s && !level_q;
      if (accept_s) begin
        level_q <= ~level_q;
        cnt_q   <= '0;
      end else if (differ_s) begin
        cnt_q   <= cnt_q + CW'(1);
      end else begin
        cnt_q   <= '0;
      end
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/timer_ctrl.sv
// Sequencing controller for the MM:SS down-counter: button conditioning,
// 1 Hz tick generation, load/count strobes and the timed alarm.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int TICK_DIV   = TICK_DIV_DEF,
  parameter int DEBOUNCE   = DEBOUNCE_DEF,
  parameter int ALARM_SECS = ALARM_SECS_DEF,
  parameter int BLINK_DIV  = BLINK_DIV_DEF
) (
  input  logic               c1khz,
  input  logic               rst,
  input  logic               btn_start,
  input  logic               btn_stop,
  input  logic               btn_load,
  input  logic               zero,
  output logic               load,
  output logic               count,
  output logic               running,
  output logic               alarm,
  output logic               alarm_blink,
  output logic [STATE_W-1:0] state
);

  localparam int PW = cnt_w(TICK_DIV);
  localparam int AW = cnt_w(ALARM_SECS * TICK_DIV);
  localparam int BW = cnt_w(BLINK_DIV);

  state_t        state_q;
  logic [PW-1:0] presc_q;
  logic [AW-1:0] alarm_cnt_q;
  logic [BW-1:0] blink_cnt_q;
  logic          zero_sync_q;
  logic          zero_s_q;
  logic          load_q;
  logic          count_q;
  logic          running_q;
  logic          alarm_q;
  logic          blink_q;

  logic          p_start_s;
  logic          p_stop_s;
  logic          p_load_s;
  logic          tick_s;
  logic          any_press_s;

  btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_start (
    .clk_i(c1khz), .rst_n_i(rst), .btn_i(btn_start), .pulse_o(p_start_s)
  );
  btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_stop (
    .clk_i(c1khz), .rst_n_i(rst), .btn_i(btn_stop), .pulse_o(p_stop_s)
  );
  btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_load (
    .clk_i(c1khz), .rst_n_i(rst), .btn_i(btn_load), .pulse_o(p_load_s)
  );

  assign tick_s      = (state_q == ST_RUN) && (presc_q == PW'(TICK_DIV - 1));
  assign any_press_s = p_start_s || p_stop_s || p_load_s;

  // Zero flag arrives from the counter's domain-free logic; synchronise it.
  always_ff @(posedge c1khz or negedge rst) begin
    if (!rst) begin
      zero_sync_q <= 1'b0;
      zero_s_q    <= 1'b0;
    end else begin
      zero_sync_q <= zero;
      zero_s_q    <= zero_sync_q;
    end
  end

  // Controller FSM with prescaler, alarm timing and registered outputs.
  always_ff @(posedge c1khz or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      presc_q     <= '0;
      alarm_cnt_q <= '0;
      blink_cnt_q <= '0;
      load_q      <= 1'b0;
      count_q     <= 1'b0;
      running_q   <= 1'b0;
      alarm_q     <= 1'b0;
      blink_q     <= 1'b0;
    end else begin
      load_q  <= 1'b0;
      count_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (p_load_s) begin
            load_q <= 1'b1;
          end else if (p_start_s && !p_stop_s && !zero_s_q) begin
            state_q   <= ST_RUN;
            running_q <= 1'b1;
            presc_q   <= '0;
          end
        end
        ST_RUN: begin
          presc_q <= tick_s ? '0 : presc_q + PW'(1);
          // Reaching zero wins over everything, including a due decrement.
          if (zero_s_q) begin
            state_q     <= ST_ALARM;
            running_q   <= 1'b0;
            alarm_q     <= 1'b1;
            blink_q     <= 1'b1;
            alarm_cnt_q <= '0;
            blink_cnt_q <= '0;
          end else begin
            count_q <= tick_s;
            if (p_stop_s) begin
              state_q   <= ST_PAUSE;
              running_q <= 1'b0;
            end
          end
        end
        ST_PAUSE: begin
          if (p_load_s) begin
            load_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else if (p_start_s && !p_stop_s) begin
            state_q   <= ST_RUN;
            running_q <= 1'b1;
            presc_q   <= '0;
          end
        end
        ST_ALARM: begin
          if (any_press_s || (alarm_cnt_q == AW'(ALARM_SECS * TICK_DIV - 1))) begin
            load_q  <= p_load_s;
            state_q <= ST_IDLE;
            alarm_q <= 1'b0;
            blink_q <= 1'b0;
          end else begin
            alarm_cnt_q <= alarm_cnt_q + AW'(1);
            if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
              blink_cnt_q <= '0;
              blink_q     <= ~blink_q;
            end else begin
              blink_cnt_q <= blink_cnt_q + BW'(1);
            end
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          running_q <= 1'b0;
          alarm_q   <= 1'b0;
          blink_q   <= 1'b0;
        end
      endcase
    end
  end

  assign load        = load_q;
  assign count       = count_q;
  assign running     = running_q;
  assign alarm       = alarm_q;
  assign alarm_blink = blink_q;
  assign state       = state_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed scoreboard bench for timer_ctrl with shortened timing parameters.
module tb_timer_ctrl;

  localparam int TD = 10;
  localparam int DB = 4;
  localparam int AS = 2;
  localparam int BD = 5;

  logic       c1khz = 1'b0;
  logic       rst = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_stop = 1'b0;
  logic       btn_load = 1'b0;
  logic       zero = 1'b0;
  logic       load;
  logic       count;
  logic       running;
  logic       alarm;
  logic       alarm_blink;
  logic [1:0] state;

  timer_ctrl #(.TICK_DIV(TD), .DEBOUNCE(DB), .ALARM_SECS(AS), .BLINK_DIV(BD)) dut (
    .c1khz(c1khz), .rst(rst), .btn_start(btn_start), .btn_stop(btn_stop),
    .btn_load(btn_load), .zero(zero), .load(load), .count(count),
    .running(running), .alarm(alarm), .alarm_blink(alarm_blink), .state(state)
  );

  always #5 c1khz = ~c1khz;

  int load_cnt = 0;
  int count_cnt = 0;

  // Strobe monitors.
  always @(posedge c1khz) begin
    if (load === 1'b1) load_cnt <= load_cnt + 1;
    if (count === 1'b1) count_cnt <= count_cnt + 1;
  end

  typedef struct {
    string      tag;
    logic [7:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_chk = 0;

  // Packed view: {0, state, load, count, running, alarm, alarm_blink}.
  function automatic logic [7:0] outs();
    return {1'b0, state, load, count, running, alarm, alarm_blink};
  endfunction

  task automatic push(input string tag, input logic [7:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic pop_chk(input logic [7:0] obs);
    exp_t e;
    n_chk++;
    if (exp_q.size() == 0) begin
      $error("FAIL scoreboard_empty: observed %0h expected nothing", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    push(tag, expv);
    pop_chk(obs);
  endtask

  // Any expectation still queued was never produced by the DUT.
  task automatic flush_missing();
    while (exp_q.size() != 0) pop_chk(8'hFF);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge c1khz);
      #1;
    end
  endtask

  task automatic go_run();
    btn_start = 1'b1;
    step(2 + DB + 1);
    chk("run_entry_state", {6'd0, state}, 8'd1);
    chk("run_entry_running", {7'd0, running}, 8'd1);
    btn_start = 1'b0;
  endtask

  initial begin
    int base;
    int first;

    rst = 1'b0;
    step(3);
    chk("reset_outs", outs(), 8'h00);
    rst = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step(1);
      chk("idle_outs", outs(), 8'h00);
    end

    // Short press is filtered out.
    base = load_cnt;
    btn_load = 1'b1;
    step(3);
    btn_load = 1'b0;
    step(12);
    chk("short_load_cnt", 8'(load_cnt - base), 8'd0);

    // Long press: one load pulse after sync + debounce + pulse register.
    base = load_cnt;
    first = 0;
    btn_load = 1'b1;
    push("load_latency", 8'(2 + DB + 1));
    for (int i = 1; i <= 20; i++) begin
      step(1);
      if (load === 1'b1 && first == 0) first = i;
    end
    btn_load = 1'b0;
    step(12);
    pop_chk(8'(first));
    chk("long_load_cnt", 8'(load_cnt - base), 8'd1);
    chk("long_load_state", {6'd0, state}, 8'd0);

    // RUN: count every TD cycles starting TD after entry.
    go_run();
    push("count_t1", 8'(TD));
    push("count_t2", 8'(2 * TD));
    push("count_t3", 8'(3 * TD));
    for (int j = 1; j <= 3 * TD; j++) begin
      step(1);
      if (count === 1'b1) pop_chk(8'(j));
    end
    flush_missing();

    // Stop -> PAUSE with no further counts.
    btn_stop = 1'b1;
    step(2 + DB + 1);
    chk("pause_entry", {6'd0, state}, 8'd2);
    btn_stop = 1'b0;
    base = count_cnt;
    step(30);
    chk("pause_no_count", 8'(count_cnt - base), 8'd0);
    chk("pause_hold", outs(), 8'h40);

    // Restart: period restarts, then zero arrives exactly on a tick.
    go_run();
    push("restart_count", 8'(TD));
    for (int j = 1; j <= TD + 7; j++) begin
      step(1);
      if (count === 1'b1) pop_chk(8'(j));
    end
    flush_missing();
    zero = 1'b1;
    step(2);
    chk("zero_sync_still_run", {6'd0, state}, 8'd1);
    step(1);
    chk("alarm_entry_no_count", outs(), 8'h63);

    for (int k = 1; k <= 24; k++) begin
      if (k < AS * TD) push("alarm_profile", {1'b0, 2'b11, 3'b000, 1'b1, ((k / BD) % 2) == 0});
      else push("alarm_done", 8'h00);
    end
    for (int k = 1; k <= 24; k++) begin
      step(1);
      pop_chk(outs());
    end

    // Start ignored while zero is still shown.
    btn_start = 1'b1;
    step(2 + DB + 1 + 5);
    chk("start_zero_ignored", outs(), 8'h00);
    btn_start = 1'b0;
    step(10);

    // Load during ALARM: load pulse and immediate return to IDLE.
    zero = 1'b0;
    step(3);
    go_run();
    zero = 1'b1;
    step(3);
    chk("alarm_again", {6'd0, state}, 8'd3);
    base = load_cnt;
    btn_load = 1'b1;
    step(2 + DB + 1);
    chk("alarm_load", outs(), 8'h10);
    btn_load = 1'b0;
    step(10);
    chk("alarm_load_cnt", 8'(load_cnt - base), 8'd1);
    zero = 1'b0;
    step(3);

    // Stop beats start in PAUSE.
    go_run();
    btn_stop = 1'b1;
    step(2 + DB + 1);
    chk("pause_entry2", {6'd0, state}, 8'd2);
    btn_stop = 1'b0;
    step(10);
    btn_start = 1'b1;
    btn_stop = 1'b1;
    step(12);
    chk("pause_start_stop", outs(), 8'h40);
    btn_start = 1'b0;
    btn_stop = 1'b0;
    step(10);

    // Load in PAUSE -> IDLE with a load pulse.
    btn_load = 1'b1;
    step(2 + DB + 1);
    chk("pause_load", outs(), 8'h10);
    btn_load = 1'b0;
    step(10);

    // Load beats start in IDLE.
    base = load_cnt;
    btn_load = 1'b1;
    btn_start = 1'b1;
    step(2 + DB + 1);
    chk("idle_load_start", outs(), 8'h10);
    step(5);
    chk("idle_load_start_state", outs(), 8'h00);
    btn_load = 1'b0;
    btn_start = 1'b0;
    step(10);
    chk("idle_load_start_cnt", 8'(load_cnt - base), 8'd1);

    // Asynchronous reset in the middle of a count strobe.
    go_run();
    first = 0;
    for (int j = 1; j <= TD + 2 && first == 0; j++) begin
      step(1);
      if (count === 1'b1) first = j;
    end
    chk("count_before_reset", 8'(first), 8'(TD));
    rst = 1'b0;
    #1;
    chk("reset_mid_strobe", outs(), 8'h00);
    step(2);
    rst = 1'b1;
    step(3);
    chk("after_reset", outs(), 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
